// File: rtl/out_fifo_drain_pkg.sv
// Shared constants and FSM encoding for the output-side FIFO drain
// and the routing stage that fills fifo4..fifo7.
package out_fifo_drain_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DEST_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/out_fifo_drain_rr_pick4.sv
// Round-robin picker: first requester at or after rr_ptr, modulo 4.
module rr_pick4
  import out_fifo_drain_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           rr_ptr,
  output logic [1:0]           gnt,
  output logic                 any_req
);

  logic [1:0] idx;

  // Walk offsets downwards so the nearest requester is written last.
  always_comb begin
    gnt     = rr_ptr;
    idx     = rr_ptr;
    any_req = |req;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (req[idx]) gnt = idx;
    end
  end

endmodule

// File: rtl/out_fifo_drain.sv
// Drains fifo4..fifo7 onto one valid/ready port with round-robin
// bursts, flagging words whose dest field disagrees with their FIFO.
module out_fifo_drain
  import out_fifo_drain_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     fifo4_out,
  input  logic [WIDTH-1:0]     fifo5_out,
  input  logic [WIDTH-1:0]     fifo6_out,
  input  logic [WIDTH-1:0]     fifo7_out,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  output logic [NUM_PORTS-1:0] pop,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [1:0]           src,
  output logic                 dest_err
);

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [1:0]       src_q, src_d;
  logic             derr_q, derr_d;

  logic [1:0]       rr_gnt;
  logic             any_req;
  logic [WIDTH-1:0] head;

  rr_pick4 u_pick (
    .req     (~fifo_empty),
    .rr_ptr  (rr_ptr_q),
    .gnt     (rr_gnt),
    .any_req (any_req)
  );

  always_comb begin
    case (gnt_q)
      2'd0:    head = fifo4_out;
      2'd1:    head = fifo5_out;
      2'd2:    head = fifo6_out;
      default: head = fifo7_out;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    src_d    = src_q;
    derr_d   = derr_q;
    pop      = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          pop[rr_gnt] = 1'b1;
          gnt_d       = rr_gnt;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        data_d  = head;
        src_d   = gnt_q;
        valid_d = 1'b1;
        derr_d  = head[WIDTH-1 -: DEST_W] != gnt_q;
        cnt_d   = (cnt_q == 4'(BURST)) ? cnt_q : cnt_q + 4'd1;
        state_d = HOLD;
      end
      HOLD: begin
        derr_d = 1'b0;
        if (ready_in) begin
          valid_d = 1'b0;
          // Keep the grant only while budget remains and data is there.
          if (cnt_q < 4'(BURST) && !fifo_empty[gnt_q]) begin
            pop[gnt_q] = 1'b1;
            state_d    = WAIT;
          end else begin
            rr_ptr_d = gnt_q + 2'd1;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      src_q    <= '0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      src_q    <= src_d;
      derr_q   <= derr_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign src       = src_q;
  assign dest_err  = derr_q;

endmodule

// File: tb/tb_out_fifo_drain.sv
// Directed bench: two drains (BURST=4 and BURST=1) fed by
// behavioural one-cycle-latency FIFOs.
module tb_out_fifo_drain;
  import out_fifo_drain_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rdy = 1'b1;

  logic [9:0] mem [2][4][16];
  logic [3:0] wp [2][4] = '{default: '0};
  logic [3:0] rp [2][4] = '{default: '0};
  logic [9:0] fo [2][4] = '{default: '0};

  logic [3:0] emp0, emp1, pa0, pa1;
  logic [9:0] do4, do1;
  logic       v4, v1, e4, e1;
  logic [1:0] s4, s1;

  int tests = 0;
  int fails = 0;

  int         es5 [7] = '{1, 1, 1, 1, 2, 1, 1};
  logic [9:0] ed5 [7] = '{10'h100, 10'h101, 10'h102,
                          10'h103, 10'h2AA, 10'h104, 10'h105};

  always #5 clk = ~clk;

  assign emp0 = {rp[0][3] == wp[0][3], rp[0][2] == wp[0][2],
                 rp[0][1] == wp[0][1], rp[0][0] == wp[0][0]};
  assign emp1 = {rp[1][3] == wp[1][3], rp[1][2] == wp[1][2],
                 rp[1][1] == wp[1][1], rp[1][0] == wp[1][0]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pa0[i] && !emp0[i]) begin
        fo[0][i] <= mem[0][i][rp[0][i]];
        rp[0][i] <= rp[0][i] + 4'd1;
      end
      if (pa1[i] && !emp1[i]) begin
        fo[1][i] <= mem[1][i][rp[1][i]];
        rp[1][i] <= rp[1][i] + 4'd1;
      end
    end
  end

  out_fifo_drain #(.WIDTH(10), .BURST(4)) dut4 (
    .clk(clk), .reset(reset),
    .fifo4_out(fo[0][0]), .fifo5_out(fo[0][1]),
    .fifo6_out(fo[0][2]), .fifo7_out(fo[0][3]),
    .fifo_empty(emp0), .pop(pa0),
    .data_out(do4), .valid_out(v4), .ready_in(rdy),
    .src(s4), .dest_err(e4)
  );

  out_fifo_drain #(.WIDTH(10), .BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .fifo4_out(fo[1][0]), .fifo5_out(fo[1][1]),
    .fifo6_out(fo[1][2]), .fifo7_out(fo[1][3]),
    .fifo_empty(emp1), .pop(pa1),
    .data_out(do1), .valid_out(v1), .ready_in(rdy),
    .src(s1), .dest_err(e1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int i, input logic [9:0] w);
    mem[d][i][wp[d][i]] = w;
    wp[d][i] = wp[d][i] + 4'd1;
  endtask

  task automatic wait_valid(input int d);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      step();
      if ((d == 1 ? v1 : v4) === 1'b1) ok = 1'b1;
    end
    chk("wait_valid", 32'(ok), 32'd1);
  endtask

  // Pop safety on both drains, sampled mid-cycle.
  always @(negedge clk) begin
    chk("pop4_empty", 32'(pa0 & emp0), 32'd0);
    chk("pop1_empty", 32'(pa1 & emp1), 32'd0);
    chk("pop4_1hot", 32'($countones(pa0) <= 1), 32'd1);
    chk("pop1_1hot", 32'($countones(pa1) <= 1), 32'd1);
  end

  initial begin
    #1;
    chk("rst_data", 32'(do4), 32'h0);
    chk("rst_valid", 32'(v4), 32'h0);
    chk("rst_src", 32'(s4), 32'h0);
    chk("rst_derr", 32'(e4), 32'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // T2 single word
    rdy = 1'b1;
    push(0, 0, 10'h00A);
    #1;
    chk("t2_pop", 32'(pa0), 32'b0001);
    step();
    chk("t2_pop_off", 32'(pa0), 32'b0000);
    step();
    chk("t2_data", 32'(do4), 32'h00A);
    chk("t2_valid", 32'(v4), 32'h1);
    chk("t2_src", 32'(s4), 32'h0);
    chk("t2_derr", 32'(e4), 32'h0);
    step();
    chk("t2_done", 32'(v4), 32'h0);
    step();

    // T4 backpressure
    rdy = 1'b0;
    push(0, 0, 10'h055);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t4_data", 32'(do4), 32'h055);
      chk("t4_valid", 32'(v4), 32'h1);
      chk("t4_pop", 32'(pa0), 32'h0);
      step();
    end
    rdy = 1'b1;
    chk("t4_last", 32'(v4), 32'h1);
    step();
    chk("t4_xfer", 32'(v4), 32'h0);
    step();

    // T1 reset mid-HOLD
    rdy = 1'b0;
    push(0, 0, 10'h0AA);
    step();
    step();
    chk("t1_held", 32'(v4), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_data", 32'(do4), 32'h0);
    chk("t1_valid", 32'(v4), 32'h0);
    chk("t1_src", 32'(s4), 32'h0);
    chk("t1_derr", 32'(e4), 32'h0);
    chk("t1_pop", 32'(pa0), 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("t1_state", 32'(dut4.state_q), 32'(IDLE));
    chk("t1_rrptr", 32'(dut4.rr_ptr_q), 32'h0);

    // T3 round-robin with BURST=1
    rdy = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        push(1, i, {2'(i), 8'(16 * i + k)});
    for (int n = 0; n < 8; n++) begin
      wait_valid(1);
      chk("t3_src", 32'(s1), 32'(n % 4));
      chk("t3_data", 32'(do1),
          32'({2'(n % 4), 8'(16 * (n % 4) + n / 4)}));
      chk("t3_derr", 32'(e1), 32'h0);
    end

    // T5 bursts on BURST=4
    for (int k = 0; k < 6; k++) push(0, 1, 10'(10'h100 + k));
    push(0, 2, 10'h2AA);
    for (int n = 0; n < 7; n++) begin
      wait_valid(0);
      chk("t5_src", 32'(s4), 32'(es5[n]));
      chk("t5_data", 32'(do4), 32'(ed5[n]));
    end

    // T6 dest mismatch
    push(0, 2, 10'h1FF);
    wait_valid(0);
    chk("t6_data", 32'(do4), 32'h1FF);
    chk("t6_src", 32'(s4), 32'h2);
    chk("t6_derr", 32'(e4), 32'h1);
    step();
    chk("t6_pulse", 32'(e4), 32'h0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
